// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states, access owner,
// wait-counter and statistics-counter widths.
package mem_port_arbiter_pkg;

  // state | meaning
  // IDLE  | no access in flight, arbitrate between requesters
  // ISSUE | ram_* driven for one cycle, write strobe active
  // WAIT  | read data still travelling through the RAM pipeline
  // DONE  | one-cycle ack to the owner, requests ignored
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  localparam int unsigned LAT_W  = 2;
  localparam int unsigned STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, loader and RAM-side signals around the arbiter.
// Optional ARB_STATS_EN adds the grant/starvation statistics outputs.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_ack;
  logic              ldr_hold;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

`ifdef ARB_STATS_EN
  logic [15:0]       cpu_grant_cnt;
  logic [15:0]       ldr_grant_cnt;
  logic [15:0]       starve_evt_cnt;
`endif

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_hold,
    output ldr_rdata, ldr_ack,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata
`ifdef ARB_STATS_EN
    , output cpu_grant_cnt, ldr_grant_cnt, starve_evt_cnt
`endif
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_hold,
    input  ldr_rdata, ldr_ack,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata
`ifdef ARB_STATS_EN
    , input cpu_grant_cnt, ldr_grant_cnt, starve_evt_cnt
`endif
  );

endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// Winner select for the RAM port plus the loader starvation counter.
// ARB_STATS_EN exposes a strobe for loader grants forced by starvation.
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  input  logic   ldr_hold_i,
  input  logic   idle_i,
  input  logic   grant_i,
  output owner_e winner_o
`ifdef ARB_STATS_EN
  , output logic forced_o
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starve_hit;

  assign starve_hit = (starve_cnt_q == STARVE_TOP) && ldr_req_i;

  // Priority: loader hold, then starvation override, then CPU default.
  always_comb begin
    winner_o = OWN_LDR;
    if (ldr_hold_i && ldr_req_i) winner_o = OWN_LDR;
    else if (starve_hit)         winner_o = OWN_LDR;
    else if (cpu_req_i)          winner_o = OWN_CPU;
  end

`ifdef ARB_STATS_EN
  assign forced_o = starve_hit && !ldr_hold_i;
`endif

  // Count CPU wins while the loader waits; any loader win or idle loader clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (idle_i) begin
      if (!ldr_req_i) begin
        starve_cnt_d = '0;
      end else if (grant_i) begin
        if (winner_o == OWN_LDR)            starve_cnt_d = '0;
        else if (starve_cnt_q != STARVE_TOP) starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between the CPU datapath and the loader/debug
// port: one RAM access per grant, one-cycle ack to the owner.
// Define ARB_STATS_EN to add saturating grant/starvation statistics.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [LAT_W-1:0] WAIT_INIT = (RD_LAT > 0) ? LAT_W'(RD_LAT - 1) : '0;

  logic [1:0]        state_q, state_d;
  owner_e            owner_q, winner;
  logic              we_q;
  logic [LAT_W-1:0]  wait_cnt_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;
  logic              cpu_ack_q, ldr_ack_q;
  logic              idle, grant, capture, finish;

  assign idle    = (state_q == IDLE);
  assign grant   = idle && (bus.cpu_req || bus.ldr_req);
  assign capture = !we_q && (((state_q == ISSUE) && (RD_LAT == 0)) ||
                             ((state_q == WAIT) && (wait_cnt_q == '0)));
  assign finish  = (state_d == DONE) && (state_q != DONE);

`ifdef ARB_STATS_EN
  logic forced;
`endif

  arb_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio_sel (
    .clk        (clk),
    .reset      (reset),
    .cpu_req_i  (bus.cpu_req),
    .ldr_req_i  (bus.ldr_req),
    .ldr_hold_i (bus.ldr_hold),
    .idle_i     (idle),
    .grant_i    (grant),
    .winner_o   (winner)
`ifdef ARB_STATS_EN
    , .forced_o (forced)
`endif
  );

  // Access sequencing: writes skip WAIT, reads wait RD_LAT cycles for data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = (!we_q && (RD_LAT != 0)) ? WAIT : DONE;
      WAIT:    if (wait_cnt_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, RAM drive registers, read-data capture and owner ack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      wait_cnt_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      if (grant) begin
        owner_q <= winner;
        if (winner == OWN_CPU) begin
          we_q        <= bus.cpu_we;
          ram_we_q    <= bus.cpu_we;
          ram_addr_q  <= bus.cpu_addr;
          ram_wdata_q <= bus.cpu_wdata;
        end else begin
          we_q        <= bus.ldr_we;
          ram_we_q    <= bus.ldr_we;
          ram_addr_q  <= bus.ldr_addr;
          ram_wdata_q <= bus.ldr_wdata;
        end
      end
      if (state_q == ISSUE) wait_cnt_q <= WAIT_INIT;
      else if ((state_q == WAIT) && (wait_cnt_q != '0)) wait_cnt_q <= wait_cnt_q - 1'b1;
      if (capture) begin
        if (owner_q == OWN_CPU) cpu_rdata_q <= bus.ram_rdata;
        else                    ldr_rdata_q <= bus.ram_rdata;
      end
      if (finish) begin
        cpu_ack_q <= (owner_q == OWN_CPU);
        ldr_ack_q <= (owner_q == OWN_LDR);
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cpu_grant_cnt_q, ldr_grant_cnt_q, starve_evt_cnt_q;

  // Saturating grant and forced-loader statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_grant_cnt_q  <= '0;
      ldr_grant_cnt_q  <= '0;
      starve_evt_cnt_q <= '0;
    end else if (grant) begin
      if (winner == OWN_CPU) cpu_grant_cnt_q <= sat_inc(cpu_grant_cnt_q);
      else                   ldr_grant_cnt_q <= sat_inc(ldr_grant_cnt_q);
      if (forced)            starve_evt_cnt_q <= sat_inc(starve_evt_cnt_q);
    end
  end

  assign bus.cpu_grant_cnt  = cpu_grant_cnt_q;
  assign bus.ldr_grant_cnt  = ldr_grant_cnt_q;
  assign bus.starve_evt_cnt = starve_evt_cnt_q;
`endif

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign bus.ldr_ack   = ldr_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances (RD_LAT 0/1/2) each with a RAM model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus2 ();

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(0), .STARVE_MAX(4))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(2), .STARVE_MAX(4))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // RAM models with read latency 0, 1 and 2.
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  logic [31:0] mem2 [512];
  logic [31:0] rd1, p1, p2;

  always @(posedge clk) if (bus0.ram_we) mem0[bus0.ram_addr] <= bus0.ram_wdata;
  assign bus0.ram_rdata = mem0[bus0.ram_addr];

  always @(posedge clk) begin
    if (bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wdata;
    rd1 <= mem1[bus1.ram_addr];
  end
  assign bus1.ram_rdata = rd1;

  always @(posedge clk) begin
    if (bus2.ram_we) mem2[bus2.ram_addr] <= bus2.ram_wdata;
    p1 <= mem2[bus2.ram_addr];
    p2 <= p1;
  end
  assign bus2.ram_rdata = p2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
    bus0.ldr_req = 0; bus0.ldr_we = 0; bus0.ldr_addr = '0; bus0.ldr_wdata = '0; bus0.ldr_hold = 0;
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.ldr_req = 0; bus1.ldr_we = 0; bus1.ldr_addr = '0; bus1.ldr_wdata = '0; bus1.ldr_hold = 0;
    bus2.cpu_req = 0; bus2.cpu_we = 0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
    bus2.ldr_req = 0; bus2.ldr_we = 0; bus2.ldr_addr = '0; bus2.ldr_wdata = '0; bus2.ldr_hold = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus1.cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_cpu_ack got %b want 0", bus1.cpu_ack); end
    checks++; if (bus1.ldr_ack !== 1'b0) begin errors++; $display("FAIL rst_ldr_ack got %b want 0", bus1.ldr_ack); end
    checks++; if (bus1.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b want 0", bus1.ram_we); end
    checks++; if (bus1.ram_addr !== 9'h000) begin errors++; $display("FAIL rst_ram_addr got %h want 000", bus1.ram_addr); end
    checks++; if (bus1.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata got %h want 0", bus1.cpu_rdata); end
    checks++; if (bus1.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_cpu_stall got %b want 0", bus1.cpu_stall); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_rw();
    int c, ca, we_seen;
    @(negedge clk);
    c = cyc;
    bus1.cpu_req = 1; bus1.cpu_we = 1; bus1.cpu_addr = 9'h0A5; bus1.cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus1.ram_we !== 1'b1) begin errors++; $display("FAIL wr_ram_we_n1 got %b want 1", bus1.ram_we); end
    checks++; if (bus1.ram_addr !== 9'h0A5) begin errors++; $display("FAIL wr_ram_addr got %h want 0a5", bus1.ram_addr); end
    checks++; if (bus1.ram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_ram_wdata got %h want deadbeef", bus1.ram_wdata); end
    checks++; if (bus1.cpu_stall !== 1'b1) begin errors++; $display("FAIL wr_stall_pending got %b want 1", bus1.cpu_stall); end
    @(negedge clk);
    checks++; if (bus1.ram_we !== 1'b0) begin errors++; $display("FAIL wr_ram_we_n2 got %b want 0", bus1.ram_we); end
    checks++; if (bus1.cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack_n2 got %b want 1 (cyc %0d)", bus1.cpu_ack, cyc - c); end
    checks++; if (bus1.cpu_stall !== 1'b0) begin errors++; $display("FAIL wr_stall_at_ack got %b want 0", bus1.cpu_stall); end
    bus1.cpu_req = 0;
    @(negedge clk);
    checks++; if (bus1.cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_one_cycle got %b want 0", bus1.cpu_ack); end
    c = cyc; ca = -1; we_seen = 0;
    bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 9'h0A5; bus1.cpu_wdata = '0;
    for (int i = 0; i < 20 && ca < 0; i++) begin
      @(negedge clk);
      if (bus1.ram_we) we_seen++;
      if (bus1.cpu_ack) begin ca = cyc; bus1.cpu_req = 0; end
    end
    checks++; if (ca !== c + 3) begin errors++; $display("FAIL rd_ack_latency got %0d want %0d", ca - c, 3); end
    checks++; if (bus1.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", bus1.cpu_rdata); end
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL rd_no_ram_we got %0d want 0", we_seen); end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int c, ca, la, ldr_early;
    logic stall_at_ack;
    @(negedge clk);
    c = cyc; ca = -1; la = -1; ldr_early = 0; stall_at_ack = 1'bx;
    bus1.ldr_hold = 0;
    bus1.cpu_req = 1; bus1.cpu_we = 1; bus1.cpu_addr = 9'h010; bus1.cpu_wdata = 32'h11111111;
    bus1.ldr_req = 1; bus1.ldr_we = 1; bus1.ldr_addr = 9'h020; bus1.ldr_wdata = 32'h22222222;
    for (int i = 0; i < 20 && (ca < 0 || la < 0); i++) begin
      @(negedge clk);
      if (ca < 0 && bus1.ldr_ack) ldr_early = 1;
      if (ca < 0 && bus1.cpu_ack) begin ca = cyc; stall_at_ack = bus1.cpu_stall; bus1.cpu_req = 0; end
      if (la < 0 && bus1.ldr_ack) begin la = cyc; bus1.ldr_req = 0; end
    end
    checks++; if (ca !== c + 2) begin errors++; $display("FAIL sim_cpu_ack got %0d want 2", ca - c); end
    checks++; if (la !== c + 5) begin errors++; $display("FAIL sim_ldr_ack got %0d want 5", la - c); end
    checks++; if (ldr_early !== 0) begin errors++; $display("FAIL sim_ldr_ack_during_cpu got %0d want 0", ldr_early); end
    checks++; if (stall_at_ack !== 1'b0) begin errors++; $display("FAIL sim_cpu_stall_at_ack got %b want 0", stall_at_ack); end
    checks++; if (mem1[9'h010] !== 32'h11111111) begin errors++; $display("FAIL sim_mem_cpu got %h want 11111111", mem1[9'h010]); end
    checks++; if (mem1[9'h020] !== 32'h22222222) begin errors++; $display("FAIL sim_mem_ldr got %h want 22222222", mem1[9'h020]); end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int n;
    logic seq [6];
    logic exp_seq [6];
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) seq[i] = 1'bx;
    @(negedge clk);
    n = 0;
    bus1.cpu_req = 1; bus1.cpu_we = 1; bus1.cpu_addr = 9'h100; bus1.cpu_wdata = 32'hC0C0C0C0;
    bus1.ldr_req = 1; bus1.ldr_we = 1; bus1.ldr_addr = 9'h101; bus1.ldr_wdata = 32'h1D1D1D1D;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (bus1.cpu_ack) begin seq[n] = 1'b0; n++; end
      else if (bus1.ldr_ack) begin seq[n] = 1'b1; n++; bus1.ldr_req = 0; end
      if (n == 6) bus1.cpu_req = 0;
    end
    bus1.cpu_req = 0; bus1.ldr_req = 0;
    checks++; if (n !== 6) begin errors++; $display("FAIL starve_ack_count got %0d want 6", n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL starve_order[%0d] got %b want %b (0=cpu 1=ldr)", i, seq[i], exp_seq[i]); end
    end
`ifdef ARB_STATS_EN
    checks++; if (bus1.starve_evt_cnt !== 16'd1) begin errors++; $display("FAIL stats_starve got %0d want 1", bus1.starve_evt_cnt); end
    checks++; if (bus1.cpu_grant_cnt !== 16'd8) begin errors++; $display("FAIL stats_cpu_grants got %0d want 8", bus1.cpu_grant_cnt); end
    checks++; if (bus1.ldr_grant_cnt !== 16'd2) begin errors++; $display("FAIL stats_ldr_grants got %0d want 2", bus1.ldr_grant_cnt); end
`endif
    @(negedge clk);
  endtask

  task automatic test_ldr_hold();
    int nl, cpu_first;
    @(negedge clk);
    nl = 0; cpu_first = -1;
    bus1.ldr_hold = 1;
    bus1.ldr_req = 1; bus1.ldr_we = 1; bus1.ldr_addr = 9'h000; bus1.ldr_wdata = 32'hA0000000;
    bus1.cpu_req = 1; bus1.cpu_we = 1; bus1.cpu_addr = 9'h1F0; bus1.cpu_wdata = 32'h5555AAAA;
    for (int i = 0; i < 60 && cpu_first < 0; i++) begin
      @(negedge clk);
      if (bus1.cpu_ack) begin cpu_first = nl; bus1.cpu_req = 0; end
      if (bus1.ldr_ack) begin
        nl++;
        if (nl < 4) begin
          bus1.ldr_addr = 9'(nl);
          bus1.ldr_wdata = 32'hA0000000 + 32'(nl);
        end else begin
          bus1.ldr_req = 0;
          bus1.ldr_hold = 0;
        end
      end
    end
    bus1.cpu_req = 0; bus1.ldr_req = 0; bus1.ldr_hold = 0;
    checks++; if (cpu_first !== 4) begin errors++; $display("FAIL hold_ldr_acks_before_cpu got %0d want 4", cpu_first); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem1[i] !== 32'hA0000000 + 32'(i)) begin errors++; $display("FAIL hold_mem[%0d] got %h want %h", i, mem1[i], 32'hA0000000 + 32'(i)); end
    end
    checks++; if (mem1[9'h1F0] !== 32'h5555AAAA) begin errors++; $display("FAIL hold_cpu_mem got %h want 5555aaaa", mem1[9'h1F0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int c, ca;
    @(negedge clk);
    c = cyc; ca = -1;
    bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 9'h0A5;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus1.cpu_ack !== 1'b0) begin errors++; $display("FAIL rstw_no_ack got %b want 0", bus1.cpu_ack); end
    checks++; if (bus1.ram_addr !== 9'h000) begin errors++; $display("FAIL rstw_ram_addr got %h want 000", bus1.ram_addr); end
    checks++; if (bus1.ram_we !== 1'b0) begin errors++; $display("FAIL rstw_ram_we got %b want 0", bus1.ram_we); end
    checks++; if (bus1.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rstw_cpu_rdata got %h want 0", bus1.cpu_rdata); end
`ifdef ARB_STATS_EN
    checks++; if (bus1.cpu_grant_cnt !== 16'd0) begin errors++; $display("FAIL rstw_stats got %0d want 0", bus1.cpu_grant_cnt); end
`endif
    reset = 1'b1;
    for (int i = 0; i < 20 && ca < 0; i++) begin
      @(negedge clk);
      if (bus1.cpu_ack) begin ca = cyc; bus1.cpu_req = 0; end
    end
    bus1.cpu_req = 0;
    checks++; if (ca !== c + 6) begin errors++; $display("FAIL rstw_reissue_ack got %0d want 6", ca - c); end
    checks++; if (bus1.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rstw_reissue_data got %h want deadbeef", bus1.cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_rd_lat();
    int c, a0, a2;
    @(negedge clk);
    c = cyc; a0 = -1; a2 = -1;
    bus0.ldr_req = 1; bus0.ldr_we = 1; bus0.ldr_addr = 9'h033; bus0.ldr_wdata = 32'h01234567;
    bus2.ldr_req = 1; bus2.ldr_we = 1; bus2.ldr_addr = 9'h1FF; bus2.ldr_wdata = 32'h89ABCDEF;
    for (int i = 0; i < 20 && (a0 < 0 || a2 < 0); i++) begin
      @(negedge clk);
      if (a0 < 0 && bus0.ldr_ack) begin a0 = cyc; bus0.ldr_req = 0; end
      if (a2 < 0 && bus2.ldr_ack) begin a2 = cyc; bus2.ldr_req = 0; end
    end
    checks++; if (a0 !== c + 2) begin errors++; $display("FAIL lat0_ldr_wr_ack got %0d want 2", a0 - c); end
    checks++; if (a2 !== c + 2) begin errors++; $display("FAIL lat2_ldr_wr_ack got %0d want 2", a2 - c); end
    @(negedge clk);
    c = cyc; a0 = -1; a2 = -1;
    bus0.cpu_req = 1; bus0.cpu_we = 0; bus0.cpu_addr = 9'h033;
    bus2.cpu_req = 1; bus2.cpu_we = 0; bus2.cpu_addr = 9'h1FF;
    for (int i = 0; i < 20 && (a0 < 0 || a2 < 0); i++) begin
      @(negedge clk);
      if (a0 < 0 && bus0.cpu_ack) begin a0 = cyc; bus0.cpu_req = 0; end
      if (a2 < 0 && bus2.cpu_ack) begin a2 = cyc; bus2.cpu_req = 0; end
    end
    checks++; if (a0 !== c + 2) begin errors++; $display("FAIL lat0_rd_ack got %0d want 2", a0 - c); end
    checks++; if (a2 !== c + 4) begin errors++; $display("FAIL lat2_rd_ack got %0d want 4", a2 - c); end
    checks++; if (bus0.cpu_rdata !== 32'h01234567) begin errors++; $display("FAIL lat0_rd_data got %h want 01234567", bus0.cpu_rdata); end
    checks++; if (bus2.cpu_rdata !== 32'h89ABCDEF) begin errors++; $display("FAIL lat2_rd_data got %h want 89abcdef", bus2.cpu_rdata); end
    @(negedge clk);
    a2 = -1;
    bus2.cpu_req = 1; bus2.cpu_we = 1; bus2.cpu_addr = 9'h000; bus2.cpu_wdata = 32'h0BADF00D;
    for (int i = 0; i < 20 && a2 < 0; i++) begin
      @(negedge clk);
      if (bus2.cpu_ack) begin a2 = cyc; bus2.cpu_req = 0; end
    end
    @(negedge clk);
    c = cyc; a2 = -1;
    bus2.ldr_req = 1; bus2.ldr_we = 0; bus2.ldr_addr = 9'h000;
    for (int i = 0; i < 20 && a2 < 0; i++) begin
      @(negedge clk);
      if (bus2.ldr_ack) begin a2 = cyc; bus2.ldr_req = 0; end
    end
    checks++; if (a2 !== c + 4) begin errors++; $display("FAIL lat2_ldr_rd_ack got %0d want 4", a2 - c); end
    checks++; if (bus2.ldr_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL lat2_ldr_rd_data got %h want 0badf00d", bus2.ldr_rdata); end
    checks++; if (bus2.cpu_rdata !== 32'h89ABCDEF) begin errors++; $display("FAIL lat2_cpu_rdata_kept got %h want 89abcdef", bus2.cpu_rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_simultaneous();
    test_starvation();
    test_ldr_hold();
    test_reset_in_wait();
    test_rd_lat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
